cmvn_stream: RTL and testbench

Parametrised streaming cepstral mean/variance normaliser for the KWS front end: out = sat(round((in - mean[ch]) * istd[ch] / 2^FRAC_BITS)).
- Per-channel coefficients are held in a writable table, not hard-coded.
- Samples arrive channel-interleaved (ch 0..NUM_CH-1 per frame) over a valid/ready stream and leave on a back-pressurable stream.
- Sits between the fbank/feature extractor and the first NN layer.

---
 rtl/cmvn_stream.sv | 213 +++++++++++++++++++++
 tb/tb_cmvn_stream.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmvn_stream.sv
// Streaming cepstral mean/variance normaliser.
// Computes out = sat(round((in - mean[ch]) * istd[ch] / 2^FRAC_BITS)) over a
// channel-interleaved valid/ready stream, using a two-stage stallable pipeline.
// Per-channel mean/istd tables can be written while the block is idle.
module cmvn_stream #(
  parameter  int DATA_W     = 32,
  parameter  int COEF_W     = 32,
  parameter  int NUM_CH     = 20,
  parameter  int NUM_FRAMES = 50,
  parameter  int FRAC_BITS  = 24,
  parameter  int SAT_EN     = 1,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     coef_we,
  input  logic                     coef_sel,
  input  logic [CH_W-1:0]          coef_addr,
  input  logic signed [COEF_W-1:0] coef_wdata,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic [CH_W-1:0]          out_ch,
  output logic                     out_last,
  output logic                     busy,
  output logic                     done
);

  localparam int TOTAL  = NUM_CH * NUM_FRAMES;
  localparam int ACC_W  = $clog2(TOTAL + 1);
  localparam int FR_W   = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
  localparam int DIFF_W = DATA_W + 1;
  localparam int PROD_W = DATA_W + COEF_W + 1;

  localparam logic signed [PROD_W-1:0] RND   = PROD_W'(1) <<< (FRAC_BITS - 1);
  localparam logic signed [PROD_W-1:0] MAX_P = (PROD_W'(1) <<< (DATA_W - 1)) - PROD_W'(1);
  localparam logic signed [PROD_W-1:0] MIN_P = -(PROD_W'(1) <<< (DATA_W - 1));

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e                     state_q;
  logic [ACC_W-1:0]           acc_q;
  logic [CH_W-1:0]            ch_q;
  logic [FR_W-1:0]            frame_q;
  logic                       done_q;

  logic signed [COEF_W-1:0]   mean_q [NUM_CH];
  logic signed [COEF_W-1:0]   istd_q [NUM_CH];

  logic                       vld_p1_q;
  logic                       last_p1_q;
  logic [CH_W-1:0]            ch_p1_q;
  logic signed [DIFF_W-1:0]   diff_p1_q;

  logic                       out_valid_q;
  logic                       out_last_q;
  logic [CH_W-1:0]            out_ch_q;
  logic signed [DATA_W-1:0]   out_data_q;

  logic                       adv_d;
  logic                       in_ready_d;
  logic                       in_fire_d;
  logic                       last_in_d;
  logic                       out_fire_d;
  logic                       coef_wr_d;
  logic signed [DIFF_W-1:0]   diff_d;
  logic signed [DATA_W-1:0]   res_d;

  // Widen both operands by one bit so the subtraction never overflows.
  function automatic logic signed [DIFF_W-1:0] sub_mean(
    input logic signed [DATA_W-1:0] x,
    input logic signed [COEF_W-1:0] m
  );
    logic signed [DIFF_W-1:0] a;
    logic signed [DIFF_W-1:0] b;
    a = DIFF_W'(x);
    b = DIFF_W'(m);
    return a - b;
  endfunction

  // Full-precision signed product of the difference and the inverse std.
  function automatic logic signed [PROD_W-1:0] mul_istd(
    input logic signed [DIFF_W-1:0] d,
    input logic signed [COEF_W-1:0] s
  );
    logic signed [PROD_W-1:0] a;
    logic signed [PROD_W-1:0] b;
    a = PROD_W'(d);
    b = PROD_W'(s);
    return a * b;
  endfunction

  // Round half toward +inf, drop the fraction, then clamp or wrap to DATA_W.
  function automatic logic signed [DATA_W-1:0] round_sat(
    input logic signed [PROD_W-1:0] p
  );
    logic signed [PROD_W-1:0] r;
    r = (p + RND) >>> FRAC_BITS;
    if (SAT_EN != 0) begin
      if (r > MAX_P) return MAX_P[DATA_W-1:0];
      if (r < MIN_P) return MIN_P[DATA_W-1:0];
    end
    return r[DATA_W-1:0];
  endfunction

  assign adv_d      = !out_valid_q || out_ready;
  assign in_ready_d = (state_q == RUN) && adv_d && (acc_q < ACC_W'(TOTAL));
  assign in_fire_d  = in_valid && in_ready_d;
  assign last_in_d  = (frame_q == FR_W'(NUM_FRAMES - 1)) && (ch_q == CH_W'(NUM_CH - 1));
  assign out_fire_d = out_valid_q && out_ready;
  assign coef_wr_d  = (state_q == IDLE) && coef_we &&
                      ({{(32 - CH_W){1'b0}}, coef_addr} < 32'(NUM_CH));
  assign diff_d     = sub_mean(in_data, mean_q[ch_q]);
  assign res_d      = round_sat(mul_istd(diff_p1_q, istd_q[ch_p1_q]));

  // Job FSM: sample/channel/frame counters and the completion pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ch_q    <= '0;
      frame_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RUN;
            acc_q   <= '0;
            ch_q    <= '0;
            frame_q <= '0;
          end
        end
        RUN: begin
          if (in_fire_d) begin
            acc_q <= acc_q + ACC_W'(1);
            if (ch_q == CH_W'(NUM_CH - 1)) begin
              ch_q    <= '0;
              frame_q <= frame_q + FR_W'(1);
            end else begin
              ch_q <= ch_q + CH_W'(1);
            end
            if (last_in_d) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (out_fire_d && out_last_q) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Coefficient tables: identity at reset, writable only while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        mean_q[i] <= '0;
        istd_q[i] <= COEF_W'(1) <<< FRAC_BITS;
      end
    end else if (coef_wr_d) begin
      if (coef_sel) istd_q[coef_addr] <= coef_wdata;
      else          mean_q[coef_addr] <= coef_wdata;
    end
  end

  // Pipeline control and output registers; everything holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q    <= 1'b0;
      last_p1_q   <= 1'b0;
      ch_p1_q     <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
    end else if (adv_d) begin
      // stage 1 -> stage 2 boundary
      vld_p1_q  <= in_fire_d;
      last_p1_q <= in_fire_d && last_in_d;
      if (in_fire_d) ch_p1_q <= ch_q;
      // stage 2 -> output boundary
      out_valid_q <= vld_p1_q;
      out_last_q  <= vld_p1_q && last_p1_q;
      if (vld_p1_q) begin
        out_ch_q   <= ch_p1_q;
        out_data_q <= res_d;
      end
    end
  end

  // Stage 1 difference register; data only, so no reset.
  always_ff @(posedge clk) begin
    if (adv_d && in_fire_d) diff_p1_q <= diff_d;
  end

  assign in_ready  = in_ready_d;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_cmvn_stream.sv
// Self-checking bench for cmvn_stream: directed corner cases plus randomized
// jobs checked against an arithmetic reference model of the normaliser.
module tb_cmvn_stream;
  localparam int DATA_W     = 32;
  localparam int COEF_W     = 32;
  localparam int NUM_CH     = 20;
  localparam int NUM_FRAMES = 50;
  localparam int FRAC_BITS  = 24;
  localparam int TOTAL      = NUM_CH * NUM_FRAMES;
  localparam int CH_W       = 5;

  logic clk = 1'b0;
  logic rst_n;
  logic start, coef_we, coef_sel;
  logic [CH_W-1:0] coef_addr;
  logic [COEF_W-1:0] coef_wdata;
  logic in_valid, in_ready;
  logic [DATA_W-1:0] in_data;
  logic out_valid, out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CH_W-1:0] out_ch;
  logic out_last, busy, done;

  cmvn_stream #(
    .DATA_W(DATA_W), .COEF_W(COEF_W), .NUM_CH(NUM_CH), .NUM_FRAMES(NUM_FRAMES),
    .FRAC_BITS(FRAC_BITS), .SAT_EN(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .coef_we(coef_we), .coef_sel(coef_sel),
    .coef_addr(coef_addr), .coef_wdata(coef_wdata), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch),
    .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] d;
    int                ch;
    bit                last;
  } exp_t;

  int tests = 0;
  int fails = 0;
  longint mean_m [NUM_CH];
  longint istd_m [NUM_CH];
  exp_t exp_q[$];
  logic [DATA_W-1:0] stim_q[$];
  logic [DATA_W-1:0] got_q[$];
  int job_acc, cyc, done_cnt, ir_bad;
  int last_hs_cyc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: plain integer arithmetic with floor division and clamping.
  function automatic logic [DATA_W-1:0] ref_out(input longint x, input int ch);
    longint d, p, r, hi, lo;
    d  = x - mean_m[ch];
    p  = d * istd_m[ch];
    r  = (p + (longint'(1) << (FRAC_BITS - 1))) >>> FRAC_BITS;
    hi = (longint'(1) << (DATA_W - 1)) - 1;
    lo = -(longint'(1) << (DATA_W - 1));
    if (r > hi) r = hi;
    if (r < lo) r = lo;
    return r[DATA_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] got_at(input int i);
    if (i < got_q.size()) return got_q[i];
    return 'x;
  endfunction

  task automatic model_identity();
    for (int i = 0; i < NUM_CH; i++) begin
      mean_m[i] = 0;
      istd_m[i] = longint'(1) << FRAC_BITS;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; coef_we = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_identity();
    exp_q.delete();
    job_acc = 0;
  endtask

  // Table write while idle; optionally with start in the same cycle.
  task automatic wcoef(input bit sel, input int addr, input logic [COEF_W-1:0] val, input bit with_start);
    coef_we = 1'b1; coef_sel = sel; coef_addr = CH_W'(addr); coef_wdata = val; start = with_start;
    @(posedge clk); #1;
    coef_we = 1'b0; start = 1'b0;
    if (addr < NUM_CH) begin
      if (sel) istd_m[addr] = longint'($signed(val));
      else     mean_m[addr] = longint'($signed(val));
    end
    if (with_start) job_acc = 0;
  endtask

  task automatic start_job();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    job_acc = 0;
  endtask

  // Feed n_in samples from stim_q and consume until n_out outputs are seen.
  task automatic run(input int n_in, input int n_out, input bit stall_en,
                     input bit rand_start, input bit rand_wr);
    int budget;
    int fed;
    int got;
    bit hold_pend;
    logic [DATA_W-1:0] hold_d;
    exp_t e;
    budget = 30 * (n_in + n_out) + 100;
    fed = 0; got = 0; hold_pend = 0; hold_d = '0;
    while ((fed < n_in || got < n_out) && budget > 0) begin
      if (hold_pend) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_data", 64'(out_data), 64'(hold_d));
      end
      if (job_acc == TOTAL && in_ready) ir_bad++;
      in_valid   = (fed < n_in) && ($urandom_range(0, 3) != 0);
      in_data    = (fed < n_in) ? stim_q[fed] : '0;
      out_ready  = stall_en ? ((cyc % 97) >= 5) : 1'b1;
      start      = rand_start && ($urandom_range(0, 7) == 0);
      coef_we    = rand_wr && ($urandom_range(0, 3) == 0);
      coef_sel   = 1'($urandom);
      coef_addr  = CH_W'($urandom_range(0, NUM_CH - 1));
      coef_wdata = $urandom;
      #1;
      if (in_valid && in_ready) begin
        e.ch   = job_acc % NUM_CH;
        e.last = (job_acc == TOTAL - 1);
        e.d    = ref_out(longint'($signed(in_data)), e.ch);
        exp_q.push_back(e);
        job_acc++;
        fed++;
      end
      if (out_valid && out_ready) begin
        chk("out_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("out_data", 64'(out_data), 64'(e.d));
          chk("out_ch", 64'(out_ch), 64'(e.ch));
          chk("out_last", 64'(out_last), 64'(e.last));
        end
        got_q.push_back(out_data);
        if (out_last) last_hs_cyc = cyc;
        got++;
      end
      hold_pend = out_valid && !out_ready;
      hold_d    = out_data;
      if (done) done_cnt++;
      @(posedge clk); #1;
      cyc++;
      budget--;
    end
    start = 1'b0; coef_we = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("run_budget", 64'(budget > 0), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] v;
    start = 0; coef_we = 0; coef_sel = 0; coef_addr = '0; coef_wdata = '0;
    in_valid = 0; in_data = '0; out_ready = 1; cyc = 0; done_cnt = 0; ir_bad = 0;
    last_hs_cyc = -1;
    rst_n = 1'b0;
    model_identity();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_ch", 64'(out_ch), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Identity transform and two-cycle latency.
    start_job();
    chk("t1_busy", 64'(busy), 64'd1);
    in_valid = 1'b1; in_data = 32'h0100_0000; out_ready = 1'b1;
    #1;
    chk("t1_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("t1_valid_t1", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    chk("t1_valid_t2", 64'(out_valid), 64'd1);
    chk("t1_data", 64'(out_data), 64'h0100_0000);
    chk("t1_ch", 64'(out_ch), 64'd0);
    chk("t1_last", 64'(out_last), 64'd0);

    // Programmed mean/istd on channel 0.
    do_reset();
    wcoef(1'b0, 0, 32'd241192656, 1'b0);
    wcoef(1'b1, 0, 32'd2730620, 1'b0);
    start_job();
    stim_q = '{32'd257969872};
    got_q.delete();
    run(1, 1, 1'b0, 1'b0, 1'b0);
    chk("t2_value", 64'(got_at(0)), 64'd2730620);

    // Rounding half toward +inf.
    do_reset();
    for (int i = 0; i < 3; i++) wcoef(1'b1, i, 32'h0080_0000, 1'b0);
    start_job();
    stim_q = '{32'd1, 32'hFFFF_FFFF, 32'd3};
    got_q.delete();
    run(3, 3, 1'b0, 1'b0, 1'b0);
    chk("t3_round_p1", 64'(got_at(0)), 64'd1);
    chk("t3_round_m1", 64'(got_at(1)), 64'd0);
    chk("t3_round_p3", 64'(got_at(2)), 64'd2);

    // Saturation, with the last write coinciding with start.
    do_reset();
    wcoef(1'b0, 25, 32'h1234_5678, 1'b0);
    wcoef(1'b1, 0, 32'h7FFF_FFFF, 1'b0);
    wcoef(1'b1, 1, 32'h7FFF_FFFF, 1'b1);
    stim_q = '{32'h7FFF_FFFF, 32'h8000_0000};
    got_q.delete();
    run(2, 2, 1'b0, 1'b0, 1'b0);
    chk("t4_sat_hi", 64'(got_at(0)), 64'h7FFF_FFFF);
    chk("t4_sat_lo", 64'(got_at(1)), 64'h8000_0000);

    // Full randomized job with periodic back-pressure and ignored starts.
    do_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      v = $urandom;
      v = $signed(v) >>> $urandom_range(0, 8);
      wcoef(1'b0, i, v, 1'b0);
      v = $urandom;
      v = $signed(v) >>> $urandom_range(0, 10);
      wcoef(1'b1, i, v, 1'b0);
    end
    start_job();
    stim_q.delete();
    for (int i = 0; i < TOTAL; i++) begin
      v = $urandom;
      v = $signed(v) >>> $urandom_range(0, 10);
      stim_q.push_back(v);
    end
    got_q.delete();
    cyc = 0; ir_bad = 0; done_cnt = 0; last_hs_cyc = -1;
    run(TOTAL, TOTAL, 1'b1, 1'b1, 1'b0);
    chk("t5_count", 64'(got_q.size()), 64'(TOTAL));
    chk("t5_in_ready_after_last", 64'(ir_bad), 64'd0);
    chk("t5_no_early_done", 64'(done_cnt), 64'd0);
    chk("t5_done", 64'(done), 64'd1);
    chk("t5_done_timing", 64'(last_hs_cyc), 64'(cyc - 1));
    chk("t5_idle", 64'(busy), 64'd0);
    @(posedge clk); #1;
    chk("t5_done_pulse", 64'(done), 64'd0);

    // Writes during RUN are locked out, then an abort mid-job.
    for (int i = 0; i < NUM_CH; i++) begin
      v = $urandom;
      v = $signed(v) >>> 4;
      wcoef(1'b0, i, v, 1'b0);
      v = $urandom;
      v = $signed(v) >>> 6;
      wcoef(1'b1, i, v, 1'b0);
    end
    start_job();
    stim_q.delete();
    for (int i = 0; i < 300; i++) stim_q.push_back($urandom);
    run(300, 290, 1'b0, 1'b1, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", 64'(in_ready), 64'd0);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_out_last", 64'(out_last), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_out_data", 64'(out_data), 64'd0);
    chk("abort_out_ch", 64'(out_ch), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_identity();
    exp_q.delete();
    job_acc = 0;
    in_valid = 1'b1; in_data = 32'h55;
    #1;
    chk("idle_no_accept", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("idle_no_output", 64'(out_valid), 64'd0);
    chk("idle_state", 64'(busy), 64'd0);
    start_job();
    stim_q.delete();
    for (int i = 0; i < 40; i++) stim_q.push_back($urandom);
    got_q.delete();
    run(40, 40, 1'b0, 1'b0, 1'b0);
    chk("t6_identity", 64'(got_at(0)), 64'(stim_q[0]));
    do_reset();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
